ws2812_stream_rx: RTL

- Decodes the single-wire WS2812-style LED stream (800 kHz, GRB, MSB-first) that the game's LED display driver emits.
- Recovers 24-bit pixel words with their index and detects frame boundaries from the >50 us low reset.
- Flags protocol violations.
- Used as the loopback checker on the display pin and as a receiver for board-to-board mirroring of the 12x16 game state.

---
 rtl/ws2812_stream_rx.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_stream_rx.sv
// WS2812-style single-wire stream receiver: recovers GRB pixel words with
// their frame index, detects the frame reset gap and flags protocol errors.
// Optional build macro WS_RX_FRAME_MAP_EN adds a per-frame nonzero-pixel map.
module ws2812_stream_rx #(
    parameter int unsigned BIT_THRESH_CYC = 30,
    parameter int unsigned MIN_HIGH_CYC   = 5,
    parameter int unsigned MAX_HIGH_CYC   = 60,
    parameter int unsigned RESET_CYC      = 2500,
    parameter int unsigned NUM_PIXELS     = 192,
    parameter int unsigned IDX_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [23:0]       pixel_data,
    output logic [IDX_W-1:0]  pixel_idx,
    output logic              pixel_valid,
    output logic              frame_done,
    output logic [IDX_W-1:0]  frame_len,
    output logic              err,
    output logic [1:0]        err_code
`ifdef WS_RX_FRAME_MAP_EN
    ,
    output logic [NUM_PIXELS-1:0] frame_map
`endif
);

    localparam int unsigned HCNT_W = $clog2(MAX_HIGH_CYC + 2);
    localparam int unsigned LCNT_W = $clog2(RESET_CYC + 1);

    localparam logic [HCNT_W-1:0] H_ONE = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] H_THR = HCNT_W'(BIT_THRESH_CYC);
    localparam logic [HCNT_W-1:0] H_MIN = HCNT_W'(MIN_HIGH_CYC);
    localparam logic [HCNT_W-1:0] H_MAX = HCNT_W'(MAX_HIGH_CYC);
    localparam logic [LCNT_W-1:0] L_ONE = LCNT_W'(1);
    localparam logic [LCNT_W-1:0] L_RST = LCNT_W'(RESET_CYC);
    localparam logic [IDX_W-1:0]  P_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0]  P_MAX = IDX_W'(NUM_PIXELS);
    localparam logic [4:0]        LAST_BIT = 5'd23;

    typedef enum logic [1:0] {
        S_WAIT_RST,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t             state_q, state_d;
    logic               din_m, din_s;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
    logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
    logic [4:0]         bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]   pixcnt_q, pixcnt_d;
    logic [23:0]        sreg_q, sreg_d;
    logic               ovf_q, ovf_d;
    logic [23:0]        pixel_data_d;
    logic [IDX_W-1:0]   pixel_idx_d;
    logic               pixel_valid_d;
    logic               frame_done_d;
    logic [IDX_W-1:0]   frame_len_d;
    logic               err_d;
    logic [1:0]         err_code_d;
    logic               abort;
    logic               new_bit;
    logic [23:0]        new_word;
`ifdef WS_RX_FRAME_MAP_EN
    logic [NUM_PIXELS-1:0] shadow_q, shadow_d;
    logic [NUM_PIXELS-1:0] frame_map_d;
`endif

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT_RST;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            bitcnt_q    <= '0;
            pixcnt_q    <= '0;
            sreg_q      <= '0;
            ovf_q       <= 1'b0;
            pixel_data  <= '0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            err         <= 1'b0;
            err_code    <= '0;
`ifdef WS_RX_FRAME_MAP_EN
            shadow_q    <= '0;
            frame_map   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            bitcnt_q    <= bitcnt_d;
            pixcnt_q    <= pixcnt_d;
            sreg_q      <= sreg_d;
            ovf_q       <= ovf_d;
            pixel_data  <= pixel_data_d;
            pixel_idx   <= pixel_idx_d;
            pixel_valid <= pixel_valid_d;
            frame_done  <= frame_done_d;
            frame_len   <= frame_len_d;
            err         <= err_d;
            err_code    <= err_code_d;
`ifdef WS_RX_FRAME_MAP_EN
            shadow_q    <= shadow_d;
            frame_map   <= frame_map_d;
`endif
        end
    end

    // Next-state, pulse measurement, bit/pixel assembly and frame bookkeeping
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bitcnt_d      = bitcnt_q;
        pixcnt_d      = pixcnt_q;
        sreg_d        = sreg_q;
        ovf_d         = ovf_q;
        pixel_data_d  = pixel_data;
        pixel_idx_d   = pixel_idx;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_len_d   = frame_len;
        err_d         = 1'b0;
        err_code_d    = err_code;
        abort         = 1'b0;
        new_bit       = (hcnt_q >= H_THR);
        new_word      = {sreg_q[22:0], new_bit};
`ifdef WS_RX_FRAME_MAP_EN
        shadow_d      = shadow_q;
        frame_map_d   = frame_map;
`endif

        case (state_q)
            S_WAIT_RST: begin
                if (din_s) begin
                    lcnt_d = '0;
                end else if (lcnt_q == L_RST) begin
                    state_d = S_IDLE;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + L_ONE;
                end
            end
            S_IDLE: begin
                if (din_s) begin
                    state_d = S_HIGH;
                    hcnt_d  = H_ONE;
                end
            end
            S_HIGH: begin
                if (hcnt_q > H_MAX) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    abort      = 1'b1;
                end else if (!din_s) begin
                    if (hcnt_q < H_MIN) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd0;
                        abort      = 1'b1;
                    end else begin
                        state_d = S_LOW;
                        lcnt_d  = L_ONE;
                        sreg_d  = new_word;
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_d = '0;
                            if (pixcnt_q < P_MAX) begin
                                pixel_data_d  = new_word;
                                pixel_idx_d   = pixcnt_q;
                                pixel_valid_d = 1'b1;
                                pixcnt_d      = pixcnt_q + P_ONE;
`ifdef WS_RX_FRAME_MAP_EN
                                shadow_d[pixcnt_q] = |new_word;
`endif
                            end else if (!ovf_q) begin
                                // Extra pixels are dropped; report only the first per frame
                                err_d      = 1'b1;
                                err_code_d = 2'd3;
                                ovf_d      = 1'b1;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + H_ONE;
                end
            end
            S_LOW: begin
                if (din_s) begin
                    state_d = S_HIGH;
                    hcnt_d  = H_ONE;
                end else if (lcnt_q == L_RST) begin
                    // Frame end: judge the frame on pre-clear counts
                    if (bitcnt_q != 5'd0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end
                    if (pixcnt_q != '0) begin
                        frame_done_d = 1'b1;
                        frame_len_d  = pixcnt_q;
`ifdef WS_RX_FRAME_MAP_EN
                        frame_map_d  = shadow_q;
`endif
                    end
                    state_d  = S_IDLE;
                    lcnt_d   = '0;
                    bitcnt_d = '0;
                    pixcnt_d = '0;
                    sreg_d   = '0;
                    ovf_d    = 1'b0;
`ifdef WS_RX_FRAME_MAP_EN
                    shadow_d = '0;
`endif
                end else begin
                    lcnt_d = lcnt_q + L_ONE;
                end
            end
            default: begin
                state_d = S_WAIT_RST;
            end
        endcase

        // Any pulse violation throws away the rest of the frame
        if (abort) begin
            state_d  = S_WAIT_RST;
            lcnt_d   = '0;
            bitcnt_d = '0;
            pixcnt_d = '0;
            sreg_d   = '0;
            ovf_d    = 1'b0;
`ifdef WS_RX_FRAME_MAP_EN
            shadow_d = '0;
`endif
        end
    end

endmodule
